// File: rtl/sun_track_ctrl.sv
// sun_track_ctrl: east/west light comparison with deadband and N-sample confirmation, driving DIR/EN of pwm_control.
// Registered outputs, DIR moves 2 cycles after the confirming sample; `SUN_TRACK_WATCHDOG_EN adds a move watchdog with sticky FAULT.
module sun_track_ctrl #(
  parameter int DATA_W     = 12,
  parameter int DEADBAND   = 16,
  parameter int CONFIRM    = 4,
  parameter int SETTLE_CYC = 100000,
  parameter int WDOG_CYC   = 50000000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SAMPLE_VALID,
  input  logic [DATA_W-1:0] LIGHT_A,
  input  logic [DATA_W-1:0] LIGHT_B,
  input  logic              LIM_CCW,
  input  logic              LIM_CW,
  output logic [1:0]        DIR,
  output logic              EN,
  output logic              FAULT
);

  localparam logic [1:0] CLS_STOP = 2'b00;
  localparam logic [1:0] CLS_CCW  = 2'b01;
  localparam logic [1:0] CLS_CW   = 2'b10;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_MOVE_CCW = 3'd1;
  localparam logic [2:0] ST_MOVE_CW  = 3'd2;
  localparam logic [2:0] ST_SETTLE   = 3'd3;
`ifdef SUN_TRACK_WATCHDOG_EN
  localparam logic [2:0] ST_FAULT    = 3'd4;
`endif

  localparam int DW1  = DATA_W + 1;
  localparam int CW_W = $clog2(CONFIRM + 1);
  localparam int SW   = $clog2(SETTLE_CYC + 1);

  localparam logic [CW_W-1:0]       CNT_MAX     = CW_W'(CONFIRM);
  localparam logic [SW-1:0]         SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic signed [DATA_W:0] DB_POS     = DW1'(DEADBAND);
  localparam logic signed [DATA_W:0] DB_NEG     = -DB_POS;

  logic signed [DATA_W:0] diff;
  logic [1:0]             cls;

  logic [1:0]      cand_q, cand_d;
  logic [CW_W-1:0] cnt_q, cnt_d;
  logic [1:0]      acc_q, acc_d;
  logic [2:0]      state_q, state_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [1:0]      dir_q, dir_d;
  logic            en_q, en_d;

`ifdef SUN_TRACK_WATCHDOG_EN
  localparam int            WW        = $clog2(WDOG_CYC + 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYC - 1);
  logic [WW-1:0] wdog_q, wdog_d;
  logic          fault_q, fault_d;
`endif

  // Zero-extended operands: the DATA_W+1 signed difference cannot overflow.
  assign diff = $signed({1'b0, LIGHT_A}) - $signed({1'b0, LIGHT_B});

  always_comb begin
    cls = CLS_STOP;
    if (diff > DB_POS)      cls = CLS_CCW;
    else if (diff < DB_NEG) cls = CLS_CW;
  end

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    if (SAMPLE_VALID) begin
      if (cls == cand_q) begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      end else begin
        cand_d = cls;
        cnt_d  = CW_W'(1);
      end
      if (cnt_d == CNT_MAX) acc_d = cand_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
`ifdef SUN_TRACK_WATCHDOG_EN
    wdog_d   = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (acc_q == CLS_CCW && !LIM_CCW)     state_d = ST_MOVE_CCW;
        else if (acc_q == CLS_CW && !LIM_CW)  state_d = ST_MOVE_CW;
      end
      ST_MOVE_CCW: begin
        if (LIM_CCW || acc_q != CLS_CCW) begin
          state_d  = ST_SETTLE;
          settle_d = '0;
        end
`ifdef SUN_TRACK_WATCHDOG_EN
        else if (wdog_q == WDOG_LAST) state_d = ST_FAULT;
        else                          wdog_d  = wdog_q + 1'b1;
`endif
      end
      ST_MOVE_CW: begin
        if (LIM_CW || acc_q != CLS_CW) begin
          state_d  = ST_SETTLE;
          settle_d = '0;
        end
`ifdef SUN_TRACK_WATCHDOG_EN
        else if (wdog_q == WDOG_LAST) state_d = ST_FAULT;
        else                          wdog_d  = wdog_q + 1'b1;
`endif
      end
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) state_d  = ST_IDLE;
        else                         settle_d = settle_q + 1'b1;
      end
`ifdef SUN_TRACK_WATCHDOG_EN
      ST_FAULT: state_d = ST_FAULT;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the FSM.
  always_comb begin
    dir_d = 2'b00;
    case (state_d)
      ST_MOVE_CCW: dir_d = 2'b01;
      ST_MOVE_CW:  dir_d = 2'b10;
      default:     dir_d = 2'b00;
    endcase
`ifdef SUN_TRACK_WATCHDOG_EN
    en_d    = (state_d != ST_FAULT);
    fault_d = (state_d == ST_FAULT);
`else
    en_d    = 1'b1;
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cand_q   <= CLS_STOP;
      cnt_q    <= '0;
      acc_q    <= CLS_STOP;
      state_q  <= ST_IDLE;
      settle_q <= '0;
      dir_q    <= 2'b00;
      en_q     <= 1'b0;
`ifdef SUN_TRACK_WATCHDOG_EN
      wdog_q   <= '0;
      fault_q  <= 1'b0;
`endif
    end else begin
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      state_q  <= state_d;
      settle_q <= settle_d;
      dir_q    <= dir_d;
      en_q     <= en_d;
`ifdef SUN_TRACK_WATCHDOG_EN
      wdog_q   <= wdog_d;
      fault_q  <= fault_d;
`endif
    end
  end

  assign DIR = dir_q;
  assign EN  = en_q;
`ifdef SUN_TRACK_WATCHDOG_EN
  assign FAULT = fault_q;
`else
  // No watchdog in this build: FAULT is constant low (WDOG_CYC is never negative).
  assign FAULT = (WDOG_CYC < 0);
`endif

endmodule

// File: tb/tb_sun_track_ctrl.sv
// Bench for sun_track_ctrl: directed scenarios plus random samples/limits/resets against a behavioural model.
module tb_sun_track_ctrl;
  localparam int DATA_W     = 12;
  localparam int DEADBAND   = 16;
  localparam int CONFIRM    = 4;
  localparam int SETTLE_CYC = 8;
  localparam int WDOG_CYC   = 64;

  logic              CLK = 1'b0;
  logic              RST;
  logic              SAMPLE_VALID;
  logic [DATA_W-1:0] LIGHT_A, LIGHT_B;
  logic              LIM_CCW, LIM_CW;
  logic [1:0]        DIR;
  logic              EN, FAULT;

  always #5 CLK = ~CLK;

  sun_track_ctrl #(
    .DATA_W(DATA_W), .DEADBAND(DEADBAND), .CONFIRM(CONFIRM),
    .SETTLE_CYC(SETTLE_CYC), .WDOG_CYC(WDOG_CYC)
  ) dut (
    .CLK(CLK), .RST(RST), .SAMPLE_VALID(SAMPLE_VALID),
    .LIGHT_A(LIGHT_A), .LIGHT_B(LIGHT_B),
    .LIM_CCW(LIM_CCW), .LIM_CW(LIM_CW),
    .DIR(DIR), .EN(EN), .FAULT(FAULT)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: direction 0 stop / 1 ccw / 2 cw, remaining settle cycles, cycles spent moving.
  int m_dir, m_en, m_fault, m_settle, m_mv, m_acc;
  int hist[$];
  logic [1:0] prev_dir = 2'b00;
  logic cur_lccw = 1'b0;
  logic cur_lcw  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int classify(input int a, input int b);
    int d;
    d = a - b;
    if (d > DEADBAND)  return 1;
    if (d < -DEADBAND) return 2;
    return 0;
  endfunction

  task automatic model_edge(input logic rst, input logic vld, input int a, input int b,
                            input logic lccw, input logic lcw);
    bit stop;
    bit same;
    if (rst) begin
      m_dir = 0; m_en = 0; m_fault = 0; m_settle = 0; m_mv = 0; m_acc = 0;
      hist.delete();
      return;
    end
    m_en = 1;
    if (m_fault != 0) begin
      m_en = 0;
    end else if (m_dir != 0) begin
      stop = (m_dir == 1) ? (lccw || m_acc != 1) : (lcw || m_acc != 2);
      if (stop) begin
        m_dir = 0;
        m_settle = SETTLE_CYC;
      end else begin
`ifdef SUN_TRACK_WATCHDOG_EN
        if (m_mv == WDOG_CYC) begin
          m_fault = 1; m_dir = 0; m_en = 0;
        end else
`endif
        m_mv++;
      end
    end else if (m_settle > 0) begin
      m_settle--;
    end else begin
      if (m_acc == 1 && !lccw)     begin m_dir = 1; m_mv = 1; end
      else if (m_acc == 2 && !lcw) begin m_dir = 2; m_mv = 1; end
    end
    // A decision is accepted once the last CONFIRM samples all agree.
    if (vld) begin
      hist.push_back(classify(a, b));
      if (hist.size() > CONFIRM) void'(hist.pop_front());
      if (hist.size() == CONFIRM) begin
        same = 1'b1;
        foreach (hist[i]) if (hist[i] != hist[0]) same = 1'b0;
        if (same) m_acc = hist[0];
      end
    end
  endtask

  task automatic step(input logic rst, input logic vld, input int a, input int b);
    RST = rst; SAMPLE_VALID = vld;
    LIGHT_A = 12'(a); LIGHT_B = 12'(b);
    LIM_CCW = cur_lccw; LIM_CW = cur_lcw;
    @(posedge CLK);
    model_edge(rst, vld, a, b, cur_lccw, cur_lcw);
    #1;
    check("dir", 32'(DIR), 32'(m_dir));
    check("en", 32'(EN), 32'(m_en));
    check("fault", 32'(FAULT), 32'(m_fault));
    check("no_reversal", 32'((prev_dir == 2'b10 && DIR == 2'b01) || (prev_dir == 2'b01 && DIR == 2'b10)), 32'd0);
    prev_dir = DIR;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2000, 2000);
  endtask

  task automatic sample(input int a, input int b);
    step(1'b0, 1'b1, a, b);
  endtask

  task automatic samples_gapped(input int n, input int d);
    for (int i = 0; i < n; i++) begin
      sample(2000 + d, 2000);
      idle(1);
    end
  endtask

  initial begin
    int ra, rb;
    ra = 2000; rb = 2000;

    step(1'b1, 1'b0, 0, 0);
    step(1'b1, 1'b0, 0, 0);
    check("reset_dir", 32'(DIR), 32'd0);
    check("reset_en", 32'(EN), 32'd0);
    check("reset_fault", 32'(FAULT), 32'd0);
    idle(2);
    check("en_after_release", 32'(EN), 32'd1);

    // Three CCW samples then a STOP sample: never confirmed.
    for (int i = 0; i < 3; i++) begin sample(1000, 900); idle(1); end
    sample(2000, 2000);
    idle(5);
    check("three_samples", 32'(DIR), 32'd0);

    // Four CCW samples: DIR=01 two edges after the fourth strobe.
    for (int i = 0; i < 3; i++) begin sample(1000, 900); idle(1); end
    sample(1000, 900);
    check("lat_edge_k", 32'(DIR), 32'd0);
    idle(1);
    check("lat_edge_k1", 32'(DIR), 32'd1);
    check("lat_en", 32'(EN), 32'd1);

    // CCW limit stops within one cycle and blocks restart while held.
    idle(3);
    cur_lccw = 1'b1;
    idle(1);
    check("lim_stop", 32'(DIR), 32'd0);
    idle(20);
    check("lim_hold", 32'(DIR), 32'd0);
    cur_lccw = 1'b0;
    idle(1);
    check("lim_release", 32'(DIR), 32'd1);

    // Confirm STOP, then +/-17 alternation and +16 at the deadband edge.
    samples_gapped(4, 0);
    for (int i = 0; i < 12; i++) begin
      sample(2000 + ((i % 2 == 0) ? 17 : -17), 2000);
      idle(1);
    end
    samples_gapped(10, 16);
    idle(12);
    check("deadband_hold", 32'(DIR), 32'd0);

    // CW move, then reversal must pass through SETTLE.
    samples_gapped(4, -100);
    idle(3);
    check("cw_move", 32'(DIR), 32'd2);
    samples_gapped(4, 100);
    idle(20);
    check("rev_ccw", 32'(DIR), 32'd1);

    // Hold CCW with no limits for longer than the watchdog window.
    idle(80);
`ifdef SUN_TRACK_WATCHDOG_EN
    check("wdog_dir", 32'(DIR), 32'd0);
    check("wdog_en", 32'(EN), 32'd0);
    check("wdog_fault", 32'(FAULT), 32'd1);
`else
    check("nowdog_dir", 32'(DIR), 32'd1);
    check("nowdog_fault", 32'(FAULT), 32'd0);
`endif

    // Reset mid-move, then a fresh full confirmation is required.
    step(1'b1, 1'b0, 0, 0);
    check("rst_mid_dir", 32'(DIR), 32'd0);
    check("rst_mid_en", 32'(EN), 32'd0);
    idle(2);
    samples_gapped(3, 100);
    idle(4);
    check("post_rst_3", 32'(DIR), 32'd0);
    sample(2100, 2000);
    idle(2);
    check("post_rst_4", 32'(DIR), 32'd1);

    // Random phase.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 5))
          0: begin rb = 2000; ra = 2000 + ($urandom_range(0, 1) ? 1 : -1) * int'($urandom_range(14, 19)); end
          1: begin rb = 2000; ra = 2000 + ($urandom_range(0, 1) ? 1 : -1) * int'($urandom_range(100, 300)); end
          2: begin rb = 2000; ra = 2000; end
          3: begin ra = 4095; rb = 0; end
          4: begin ra = 0; rb = 4095; end
          default: begin ra = int'($urandom_range(0, 4095)); rb = int'($urandom_range(0, 4095)); end
        endcase
      end
      if ($urandom_range(0, 39) == 0) cur_lccw = ~cur_lccw;
      if ($urandom_range(0, 39) == 0) cur_lcw  = ~cur_lcw;
      step(($urandom_range(0, 599) == 0), 1'($urandom_range(0, 1)), ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sun_track_ctrl.md
# sun_track_ctrl

Direction-decision stage feeding `pwm_control`. Compares two light-sensor samples (east/west pair), applies a deadband and N-sample confirmation, and drives `DIR`/`EN` of the downstream servo PWM generator through a small motion FSM with end-of-travel limits and a post-stop settle interval.

## Interface
- `DATA_W`, 12: width of each light sample (unsigned).
- `DEADBAND`, 16: minimum |A−B| that requests motion (strictly greater).
- `CONFIRM`, 4: consecutive valid samples with identical classification needed to accept a decision (≥1).
- `SETTLE_CYC`, 100000: cycles held in SETTLE after any stop (≥1).
- `WDOG_CYC`, 50000000: maximum cycles in one continuous move (watchdog build only).

- `CLK`  in  1  system clock; all logic on rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `SAMPLE_VALID`  in  1  one-cycle strobe; `LIGHT_A`/`LIGHT_B` valid this cycle.
- `LIGHT_A`  in  DATA_W  sensor on CCW side.
- `LIGHT_B`  in  DATA_W  sensor on CW side.
- `LIM_CCW`  in  1  CCW end-of-travel switch, active-high, already synchronised.
- `LIM_CW`  in  1  CW end-of-travel switch, active-high, already synchronised.
- `DIR`  out  2  to `pwm_control`: 00 stop, 01 CCW, 10 CW; 11 never driven.
- `EN`  out  1  to `pwm_control` enable.
- `FAULT`  out  1  watchdog trip, sticky.

## Operation
- Classification on each `SAMPLE_VALID`: diff = A−B as signed DATA_W+1 bits, no overflow. diff > DEADBAND → CCW; diff < −DEADBAND → CW; else STOP (|diff| = DEADBAND is STOP).
- Confirm logic: registers `cand` and `cnt`. Same class as `cand` → cnt+1, saturating at CONFIRM; different class → cand=class, cnt=1. When cnt reaches CONFIRM, `accepted` ← cand. `accepted` holds between samples. Reset: cand=STOP, cnt=0, accepted=STOP.
- FSM states / outputs: IDLE (DIR 00), MOVE_CCW (01), MOVE_CW (10), SETTLE (00), FAULT (00, watchdog build only).
- IDLE: accepted=CCW and !LIM_CCW → MOVE_CCW; accepted=CW and !LIM_CW → MOVE_CW; otherwise stay.
- MOVE_CCW: LIM_CCW, or accepted≠CCW → SETTLE. MOVE_CW symmetric with LIM_CW. Direct reversal never occurs; always passes through SETTLE.
- SETTLE: counter loads 0 on entry, → IDLE when it reaches SETTLE_CYC−1. Sampling/confirmation continues during SETTLE; decision acted on from IDLE.
- Both limits high: no motion started; a move in progress stops.
- `EN` = 1 in every state except FAULT; 0 during reset.
- Reset (any time, mid-move included): next edge all registers to reset values, outputs DIR=00, EN=0, FAULT=0; EN=1 from first edge with RST low.

## Timing
- All outputs registered, decoded from state.
- Sample latency: confirming `SAMPLE_VALID` at edge k updates `accepted`; FSM transitions at edge k+1; `DIR` changes after edge k+1 (2 cycles).
- Limit latency: limit high at edge n → `DIR`=00 after edge n (1 cycle).
- Minimum stop-to-move time: SETTLE_CYC cycles in SETTLE + 1 IDLE cycle.
- `SAMPLE_VALID` held high multiple cycles counts as one sample per cycle.

## Configuration
- `SUN_TRACK_WATCHDOG_EN` defined: counter runs in MOVE_CCW/MOVE_CW, cleared on entry; reaching WDOG_CYC → FAULT state: DIR=00, EN=0, FAULT=1, exits only on RST.
- Undefined: no watchdog counter, FAULT state absent, `FAULT` tied 0, `WDOG_CYC` unused.

## Test plan
Bench parameters: DATA_W=12, DEADBAND=16, CONFIRM=4, SETTLE_CYC=8, WDOG_CYC=64.
- Four valid samples A=1000,B=900 → DIR=01 exactly 2 cycles after 4th strobe, EN=1; only 3 such samples → DIR stays 00.
- Samples alternating A−B=+17/−17 → cnt never reaches 4, DIR stays 00; A−B=+16 ×10 → DIR 00.
- In MOVE_CCW, assert LIM_CCW → DIR=00 next cycle, 8 cycles SETTLE, then IDLE stays 00 while LIM_CCW high despite accepted=CCW.
- In MOVE_CW, confirm CCW (4× A−B=+100) → DIR 10→00, 8 cycles later DIR=01; never 10→01 directly.
- Watchdog build: hold CCW decision, no limits → after 64 move cycles DIR=00, EN=0, FAULT=1, persisting until RST; non-watchdog build: DIR stays 01, FAULT=0.
- RST pulsed mid-move → next edge DIR=00, EN=0; after release, fresh CONFIRM=4 samples needed before motion.
